// File: rtl/ch_sequencer.sv
// ch_sequencer: snapshots up to NCH samples per decimated strobe and
// streams them one beat per handshake, channel 0 first.
//
// Ports:
//   clk, rst (sync, active-low)     - clock and reset
//   enable, strobe, numch, d_in     - frame start control and samples
//   out_ready                       - downstream accept
//   clr_ovr                         - clears overrun flag and counter
//   out_valid/out_data/out_chan     - sample stream
//   out_first/out_last              - frame delimiters
//   busy                            - high while sending a frame
//   overrun, ovr_cnt                - dropped-strobe flag and count
//   frame_cnt                       - completed frames (wrapping)
module ch_sequencer #(
    parameter int NCH  = 8,
    parameter int DW   = 16,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              strobe,
    input  logic [3:0]        numch,
    input  logic [NCH*DW-1:0] d_in,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [2:0]        out_chan,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    output logic [CNTW-1:0]   ovr_cnt,
    output logic [CNTW-1:0]   frame_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] shadow [NCH];
    logic [3:0]    nlat;
    logic [2:0]    idx;

    logic start;
    logic hs;
    logic last;
    logic done;
    logic load;
    logic drop;

    assign start = strobe & enable & (numch != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        hs        = 1'b0;
        last      = 1'b0;
        done      = 1'b0;
        drop      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_chan  = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                hs   = out_ready;
                last = ({1'b0, idx} == nlat - 4'd1);
                done = hs & last;
                if (done) begin
                    if (start) load = 1'b1;
                    else       state_nx = IDLE;
                end
                // A strobe is only consumed by a same-edge restart.
                drop      = strobe & ~(done & start);
                out_valid = 1'b1;
                out_data  = shadow[idx];
                out_chan  = idx;
                out_first = (idx == 3'd0);
                out_last  = last;
                busy      = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) shadow[k] <= '0;
            nlat      <= '0;
            idx       <= '0;
            overrun   <= 1'b0;
            ovr_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (load) begin
                for (int k = 0; k < NCH; k++)
                    shadow[k] <= d_in[k*DW +: DW];
                nlat <= (numch > 4'(NCH)) ? 4'(NCH) : numch;
                idx  <= '0;
            end else if (hs && !last) begin
                idx <= idx + 3'd1;
            end
            if (done) frame_cnt <= frame_cnt + 1'b1;
            // Clear takes priority over a drop on the same edge.
            if (clr_ovr) begin
                overrun <= 1'b0;
                ovr_cnt <= '0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end

endmodule
